// File: rtl/pcie_rx_gpio_wr.sv
// pcie_rx_gpio_wr: watches the 16-bit PCIe receive stream, decodes single-DW
// 3DW memory writes to two 32-bit GPIO registers, returns flow-control
// credits for every TLP that ends and counts TLPs it had to discard.
// The payload arrives in wire byte order (byte lane 0 in bits [31:24]);
// byte lane i, enabled by first-DW BE bit i, lands in register bits [8i+7:8i].
module pcie_rx_gpio_wr #(
  parameter int         BAR_IDX = 0,
  parameter logic [5:0] OFS_A   = 6'h00,
  parameter logic [5:0] OFS_B   = 6'h01
) (
  input  logic        clk,
  input  logic        perstn,
  input  logic [15:0] rx_data,
  input  logic        rx_st,
  input  logic        rx_end,
  input  logic [6:0]  rx_bar_hit,
  output logic [31:0] gpio_a,
  output logic [31:0] gpio_b,
  output logic        wr_pulse,
  output logic        ph_processed,
  output logic        nph_processed,
  output logic        pd_processed,
  output logic [7:0]  pd_num,
  output logic [7:0]  drop_cnt
);

  typedef enum logic [1:0] {IDLE, HDR, DATA, DROP} state_t;

  state_t      state;
  logic [2:0]  cnt;       // index of the word arriving this cycle (w1..w7)

  // Header and payload fields captured from the current TLP
  logic [7:0]  fmt_type;
  logic [9:0]  len;       // 0 until w1 arrives
  logic [3:0]  be;
  logic [5:0]  ofs;
  logic        bar_ok;
  logic [15:0] data_hi;

  logic        busy, abandon, finish, accept, one_word, credit;
  logic        hdr_ok, posted, with_data, ofs_hit;
  logic [9:0]  credit_len;
  logic [10:0] len_dw, len_rnd;
  logic [7:0]  pd_sat;
  logic [1:0]  drop_inc;
  logic [8:0]  drop_sum;
  logic [31:0] payload, merged_a, merged_b;

  assign busy      = (state != IDLE);
  assign abandon   = busy & rx_st;             // new rx_st cuts the current TLP short
  assign finish    = busy & ~rx_st & rx_end;   // current TLP ends on this word
  assign accept    = finish & (state == DATA) & (cnt == 3'd7);
  assign one_word  = rx_st & rx_end;
  assign credit    = abandon | finish;
  assign hdr_ok    = (fmt_type == 8'h40) && (len == 10'd1) && bar_ok;
  assign with_data = fmt_type[6];
  assign posted    = fmt_type[6] | (fmt_type[4:3] == 2'b10);
  assign ofs_hit   = (ofs == OFS_A) || (ofs == OFS_B);

  // Length seen by the credit logic: w1 is still on the bus if the TLP ends there
  assign credit_len = (finish && state == HDR && cnt == 3'd1) ? rx_data[9:0] : len;
  assign len_dw     = (credit_len == 10'd0) ? 11'd1024 : {1'b0, credit_len};
  assign len_rnd    = len_dw + 11'd3;
  assign pd_sat     = len_rnd[10] ? 8'hFF : len_rnd[9:2];

  assign drop_inc = {1'b0, abandon} + {1'b0, finish & ~accept} + {1'b0, one_word};
  assign drop_sum = {1'b0, drop_cnt} + {7'd0, drop_inc};

  assign payload = {data_hi, rx_data};

  // Byte-enable merge of the incoming payload into both registers
  always_comb begin
    // NOTE: both outputs get a full default first so no latch can be inferred.
    merged_a = gpio_a;
    merged_b = gpio_b;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        merged_a[8*i +: 8] = payload[31-8*i -: 8];
        merged_b[8*i +: 8] = payload[31-8*i -: 8];
      end
    end
  end

  // Receive FSM, register writes, credit pulses and drop counter
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments throughout so every register sees pre-edge values.
    if (!perstn) begin
      state         <= IDLE;
      cnt           <= 3'd0;
      gpio_a        <= 32'h0000_0000;
      gpio_b        <= 32'h0000_0000;
      wr_pulse      <= 1'b0;
      ph_processed  <= 1'b0;
      nph_processed <= 1'b0;
      pd_processed  <= 1'b0;
      pd_num        <= 8'h00;
      drop_cnt      <= 8'h00;
    end else begin
      wr_pulse      <= accept & ofs_hit;
      ph_processed  <= credit & posted;
      nph_processed <= credit & ~posted;
      pd_processed  <= credit & with_data;
      pd_num        <= (credit & with_data) ? pd_sat : 8'h00;
      drop_cnt      <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      if (accept && ofs == OFS_A) gpio_a <= merged_a;
      if (accept && ofs == OFS_B) gpio_b <= merged_b;

      if (rx_st) begin
        state <= rx_end ? IDLE : HDR;
        cnt   <= 3'd1;
      end else begin
        case (state)
          HDR: begin
            cnt <= cnt + 3'd1;
            if (rx_end)            state <= IDLE;
            else if (cnt == 3'd5)  state <= hdr_ok ? DATA : DROP;
          end
          DATA: begin
            cnt <= cnt + 3'd1;
            if (rx_end)            state <= IDLE;
            else if (cnt == 3'd7)  state <= DROP;
          end
          default: begin
            if (rx_end) state <= IDLE;
          end
        endcase
      end
    end
  end

  // Field capture from the word stream
  always_ff @(posedge clk) begin
    // NOTE: no reset here; every field is loaded by the current TLP before it is read.
    if (rx_st) begin
      fmt_type <= rx_data[15:8];
      bar_ok   <= |(rx_bar_hit & (7'd1 << BAR_IDX));
      len      <= 10'd0;
    end else if (state == HDR) begin
      if (cnt == 3'd1) len <= rx_data[9:0];
      if (cnt == 3'd3) be  <= rx_data[3:0];
      if (cnt == 3'd5) ofs <= rx_data[7:2];
    end else if (state == DATA && cnt == 3'd6) begin
      data_hi <= rx_data;
    end
  end

endmodule

// File: tb/tb_pcie_rx_gpio_wr.sv
// tb_pcie_rx_gpio_wr: drives directed and random TLP streams into
// pcie_rx_gpio_wr and compares every cycle against a transaction-level model
// that keeps the words of the open TLP in a queue and judges each TLP as a
// whole when it ends or is cut short.
module tb_pcie_rx_gpio_wr;

  localparam int         BAR_IDX = 0;
  localparam logic [5:0] OFS_A   = 6'h00;
  localparam logic [5:0] OFS_B   = 6'h01;
  localparam logic [6:0] HIT     = 7'd1 << BAR_IDX;

  logic        clk = 1'b0;
  logic        perstn = 1'b0;
  logic [15:0] rx_data = 16'h0000;
  logic        rx_st = 1'b0;
  logic        rx_end = 1'b0;
  logic [6:0]  rx_bar_hit = 7'h00;
  logic [31:0] gpio_a, gpio_b;
  logic        wr_pulse, ph_processed, nph_processed, pd_processed;
  logic [7:0]  pd_num, drop_cnt;

  always #4 clk = ~clk;

  pcie_rx_gpio_wr #(.BAR_IDX(BAR_IDX), .OFS_A(OFS_A), .OFS_B(OFS_B)) dut (
    .clk(clk), .perstn(perstn), .rx_data(rx_data), .rx_st(rx_st), .rx_end(rx_end),
    .rx_bar_hit(rx_bar_hit), .gpio_a(gpio_a), .gpio_b(gpio_b), .wr_pulse(wr_pulse),
    .ph_processed(ph_processed), .nph_processed(nph_processed),
    .pd_processed(pd_processed), .pd_num(pd_num), .drop_cnt(drop_cnt)
  );

  int    tests_run = 0;
  int    tests_failed = 0;
  string phase = "init";

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s/%s: got %h expected %h", phase, tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] tlp_q[$];
  logic        tlp_bar;
  logic [31:0] ref_a = 32'h0, ref_b = 32'h0;
  int          ref_drop = 0;
  logic        exp_wr, exp_ph, exp_nph, exp_pd;
  logic [7:0]  exp_pd_num;

  function automatic logic [31:0] swap32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  task automatic count_drop();
    if (ref_drop < 255) ref_drop++;
  endtask

  // Judge the queued TLP once it is complete (by_end) or cut short
  task automatic model_close(input bit by_end);
    int          n, len, dw, credits;
    logic [15:0] w1;
    logic [7:0]  ft;
    logic [7:0]  wire_b[4];
    logic [3:0]  be;
    logic [5:0]  ofs;
    n = tlp_q.size();
    if (n == 1 && by_end) begin
      count_drop();
      return;
    end
    ft = tlp_q[0][15:8];
    len = 0;
    if (n >= 2) begin
      w1 = tlp_q[1];
      len = int'(w1[9:0]);
    end
    if (ft[6] || ft[4:3] == 2'b10) exp_ph = 1'b1;
    else                            exp_nph = 1'b1;
    if (ft[6]) begin
      dw = (len == 0) ? 1024 : len;
      credits = (dw + 3) / 4;
      exp_pd = 1'b1;
      exp_pd_num = (credits > 255) ? 8'hFF : 8'(credits);
    end
    if (by_end && n == 8 && ft == 8'h40 && len == 1 && tlp_bar) begin
      ofs = tlp_q[5][7:2];
      be  = tlp_q[3][3:0];
      wire_b[0] = tlp_q[6][15:8];
      wire_b[1] = tlp_q[6][7:0];
      wire_b[2] = tlp_q[7][15:8];
      wire_b[3] = tlp_q[7][7:0];
      if (ofs == OFS_A || ofs == OFS_B) exp_wr = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (be[i] && ofs == OFS_A) ref_a[8*i +: 8] = wire_b[i];
        if (be[i] && ofs == OFS_B) ref_b[8*i +: 8] = wire_b[i];
      end
    end else begin
      count_drop();
    end
  endtask

  // Drive one word, update the model, clock it and compare
  task automatic step(input logic [15:0] d, input logic st, input logic en, input logic [6:0] bar);
    rx_data = d; rx_st = st; rx_end = en; rx_bar_hit = bar;
    exp_wr = 1'b0; exp_ph = 1'b0; exp_nph = 1'b0; exp_pd = 1'b0; exp_pd_num = 8'h00;
    if (st) begin
      if (tlp_q.size() != 0) model_close(1'b0);
      tlp_q.delete();
      tlp_q.push_back(d);
      tlp_bar = |(bar & HIT);
    end else if (tlp_q.size() != 0) begin
      tlp_q.push_back(d);
    end
    if (en && tlp_q.size() != 0) begin
      model_close(1'b1);
      tlp_q.delete();
    end
    @(posedge clk); #1;
    check("pulses", 32'({wr_pulse, ph_processed, nph_processed, pd_processed}),
          32'({exp_wr, exp_ph, exp_nph, exp_pd}));
    if (exp_pd) check("pd_num", 32'(pd_num), 32'(exp_pd_num));
    check("gpio_a", gpio_a, ref_a);
    check("gpio_b", gpio_b, ref_b);
    check("drop_cnt", 32'(drop_cnt), 32'(ref_drop));
    rx_st = 1'b0; rx_end = 1'b0;
  endtask

  task automatic idle_word();
    step(16'($urandom), 1'b0, ($urandom_range(0, 3) == 0), 7'($urandom));
  endtask

  task automatic do_reset();
    perstn = 1'b0; rx_st = 1'b0; rx_end = 1'b0; rx_data = 16'($urandom);
    tlp_q.delete();
    ref_a = 32'h0; ref_b = 32'h0; ref_drop = 0;
    @(posedge clk); #1;
    check("rst_pulses", 32'({wr_pulse, ph_processed, nph_processed, pd_processed}), 32'h0);
    check("rst_pd_num", 32'(pd_num), 32'h0);
    check("rst_gpio_a", gpio_a, 32'h0);
    check("rst_gpio_b", gpio_b, 32'h0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'h0);
    perstn = 1'b1;
  endtask

  // Build a TLP word by word; nw words, rx_end on the last one when fin
  task automatic send_tlp(input logic [7:0] ft, input logic [9:0] len, input logic [6:0] bar,
                          input logic [3:0] be, input logic [5:0] ofs, input logic [31:0] pay,
                          input int nw, input bit fin);
    logic [15:0] w;
    for (int i = 0; i < nw; i++) begin
      w = 16'($urandom);
      case (i)
        0: w[15:8] = ft;
        1: w[9:0]  = len;
        3: w[3:0]  = be;
        5: w[7:2]  = ofs;
        6: w       = pay[31:16];
        7: w       = pay[15:0];
        default: ;
      endcase
      step(w, (i == 0), (fin && i == nw - 1), (i == 0) ? bar : 7'($urandom));
    end
  endtask

  initial begin
    int          kind;
    logic [7:0]  ft;
    logic [9:0]  len;
    logic [6:0]  bar;
    logic [5:0]  ofs;
    int          nw;
    bit          fin;

    repeat (2) @(posedge clk);
    phase = "reset";
    do_reset();

    phase = "mwr_a";
    send_tlp(8'h40, 10'd1, 7'h01, 4'hF, OFS_A, swap32(32'hDEADBEEF), 8, 1'b1);
    check("wr_pulse", 32'(wr_pulse), 32'h1);
    check("ph_pd", 32'({ph_processed, pd_processed}), 32'h3);
    check("pd_num", 32'(pd_num), 32'h1);
    check("gpio_a_value", gpio_a, 32'hDEADBEEF);

    phase = "mwr_b_be3";
    send_tlp(8'h40, 10'd1, 7'h01, 4'b0011, OFS_B, swap32(32'h12345678), 8, 1'b1);
    check("gpio_b_value", gpio_b, 32'h0000_5678);

    phase = "mrd";
    send_tlp(8'h00, 10'd1, 7'h01, 4'hF, OFS_A, 32'h0, 6, 1'b1);
    check("nph", 32'(nph_processed), 32'h1);
    check("wr_pulse", 32'(wr_pulse), 32'h0);
    check("drop_cnt", 32'(drop_cnt), 32'h1);
    check("gpio_a_kept", gpio_a, 32'hDEADBEEF);

    phase = "mwr_len2_nobar";
    send_tlp(8'h40, 10'd2, 7'h00, 4'hF, OFS_A, 32'h0, 10, 1'b1);
    check("ph_pd", 32'({ph_processed, pd_processed}), 32'h3);
    check("pd_num", 32'(pd_num), 32'h1);
    check("drop_cnt", 32'(drop_cnt), 32'h2);

    phase = "pd_sat";
    send_tlp(8'h40, 10'd0, HIT, 4'hF, OFS_A, 32'h0, 4, 1'b1);
    check("pd_num_len0", 32'(pd_num), 32'hFF);
    send_tlp(8'h40, 10'd9, HIT, 4'hF, OFS_A, 32'h0, 4, 1'b1);
    check("pd_num_len9", 32'(pd_num), 32'h3);

    phase = "restart_at_w4";
    do_reset();
    send_tlp(8'h40, 10'd1, HIT, 4'hF, OFS_A, 32'h0, 4, 1'b0);
    send_tlp(8'h40, 10'd1, HIT, 4'hF, OFS_A, swap32(32'hCAFEF00D), 8, 1'b1);
    check("drop_cnt", 32'(drop_cnt), 32'h1);
    check("gpio_a_value", gpio_a, 32'hCAFEF00D);

    phase = "reset_mid_tlp";
    send_tlp(8'h40, 10'd1, HIT, 4'hF, OFS_B, 32'h0, 5, 1'b0);
    do_reset();
    step(16'h4000, 1'b0, 1'b0, HIT);
    step(16'h0001, 1'b0, 1'b0, HIT);
    step(16'hFFFF, 1'b0, 1'b1, HIT);
    send_tlp(8'h40, 10'd1, HIT, 4'b1100, OFS_B, swap32(32'hA1B2C3D4), 8, 1'b1);
    check("gpio_b_value", gpio_b, 32'hA1B2_0000);

    phase = "random";
    for (int t = 0; t < 400; t++) begin
      kind = $urandom_range(0, 9);
      ft = 8'h40; len = 10'd1; bar = 7'($urandom) | HIT; nw = 8; fin = 1'b1;
      case ($urandom_range(0, 2))
        0: ofs = OFS_A;
        1: ofs = OFS_B;
        default: ofs = 6'($urandom);
      endcase
      case (kind)
        3: begin ft = 8'($urandom); nw = $urandom_range(2, 10); end
        4: begin len = 10'($urandom); nw = $urandom_range(2, 12); end
        5: bar = 7'($urandom) & ~HIT;
        6: nw = $urandom_range(2, 7);
        7: begin fin = 1'b0; nw = $urandom_range(1, 8); end
        8: nw = 1;
        9: nw = $urandom_range(9, 12);
        default: ;
      endcase
      send_tlp(ft, len, bar, 4'($urandom), ofs, $urandom, nw, fin);
      if (fin) repeat ($urandom_range(0, 2)) idle_word();
    end

    phase = "drop_saturation";
    do_reset();
    for (int t = 0; t < 300; t++) send_tlp(8'h00, 10'd1, HIT, 4'hF, OFS_A, 32'h0, 6, 1'b1);
    check("drop_cnt_sat", 32'(drop_cnt), 32'hFF);
    do_reset();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
